envelope_adsr: RTL and testbench
================================

// Module: envelope_adsr
// PURPOSE
//  Stage directly downstream of the oscillator sources: consumes a signed sample stream over
//  valid/ready, scales each sample by an ADSR envelope gain driven by a note gate, and emits
//  the scaled stream over valid/ready toward the mixer/DAC path.
//  Envelope advances once per accepted input sample (sample-rate time base).
// PARAMETERS
//  width_p          12     sample width, signed two's complement, in and out
//  env_width_p      16     envelope gain width, unsigned; full scale = 2**env_width_p-1
//  attack_step_p    16384  gain increment per accepted sample in ATTACK
//  decay_step_p     8192   gain decrement per accepted sample in DECAY
//  sustain_level_p  32768  gain held in SUSTAIN; must be < 2**env_width_p
//  release_step_p   4096   gain decrement per accepted sample in RELEASE
// PORTS
//  clk_i     in   1            clock; sole clock
//  reset_ni  in   1            reset, synchronous, active-low
//  gate_i    in   1            note on (1) / note off (0); sampled only on input handshake
//  valid_i   in   1            input sample valid
//  data_i    in   width_p      input sample, signed
//  ready_o   out  1            block can accept data_i this cycle
//  valid_o   out  1            output sample valid
//  data_o    out  width_p      scaled output sample, signed
//  ready_i   in   1            downstream accepts data_o
// BEHAVIOUR
//  - Reset (reset_ni=0 at clk edge): state=IDLE, env=0, valid_o=0, data_o=0; wins over all else.
//  - Handshake: accept = valid_i & ready_o; ready_o = ~valid_o | ready_i (1-deep output reg).
//    On accept: data_o <= scaled sample, valid_o <= 1. If ready_i & valid_o & ~accept: valid_o<=0.
//    Latency 1 cycle; full throughput with ready_i=1. data_o/valid_o stable while ready_i=0.
//  - Scaling: prod = data_i * $signed({1'b0,env}) (width_p+env_width_p+1 bits, signed);
//    data_o = (prod >>> env_width_p) truncated to width_p (floor; cannot overflow).
//    Uses env value BEFORE this accept's update.
//  - FSM (transitions and env update only on accept; env held otherwise):
//    IDLE:    env=0; gate=1 -> ATTACK.
//    ATTACK:  gate=0 -> RELEASE (env unchanged); else env=min(env+attack_step, max);
//             reaching max -> DECAY.
//    DECAY:   gate=0 -> RELEASE; else env=max(env-decay_step, sustain); reaching sustain -> SUSTAIN.
//    SUSTAIN: env held; gate=0 -> RELEASE.
//    RELEASE: gate=1 -> ATTACK (retrigger, see macro); else env=max(env-release_step,0);
//             reaching 0 -> IDLE.
//  - Add/sub computed at env_width_p+1 bits then saturated; no wrap-around ever.
//  - Gate changes between handshakes are ignored until the next accept.
// CONFIGURATION
//  ENVELOPE_HARD_RETRIG_EN defined: gate=1 in RELEASE forces env=0 then ATTACK (hard retrigger).
//  Not defined: ATTACK resumes from current env (soft retrigger, click-free). Default: undefined.
// STRUCTURE
//  envelope_pkg: typedef enum logic [2:0] env_state_e {IDLE,ATTACK,DECAY,SUSTAIN,RELEASE};
//    env_max function of env_width_p.
//  Sub-module envelope_fsm: state + env register, gate/step inputs, advance strobe, env_o.
//  Top: handshake, multiplier, output register.
// TESTING (defaults; ready_i=1 unless stated)
//  1 Reset: reset_ni=0 2 cycles, valid_i=1 -> valid_o=0, data_o=0; then gate=0, data_i=2047 -> data_o=0.
//  2 Attack: gate=1, data_i=2047 each cycle -> data_o 0,511,1023,1535,2046; data_i=-2048 at
//    env=max -> data_o=-2048 (floor).
//  3 Decay: after max, env 57343,49151,40959,32768 then held; SUSTAIN, data_i=2047 -> 1023 steady.
//  4 Backpressure: ready_i=0 with valid_o=1 -> ready_o=0, data_o stable, env frozen 5 cycles.
//  5 Release: gate=0 at env=32768 -> 8 accepts to env=0, IDLE; gate=1 at env=16384 -> next env
//    32768 (soft) / 16384 (ENVELOPE_HARD_RETRIG_EN: forced 0, +16384 on following accept).
//  6 Reset mid-SUSTAIN with valid_o=1 -> next cycle valid_o=0, env=0, IDLE.

Source files
------------

// File: rtl/envelope_pkg.sv
// rtl/envelope_pkg.sv - shared state encoding and envelope full-scale helper for envelope_adsr
package envelope_pkg;

  typedef enum logic [2:0] {
    IDLE,
    ATTACK,
    DECAY,
    SUSTAIN,
    RELEASE
  } env_state_e;

  function automatic int unsigned env_max(input int unsigned env_width);
    return (32'd1 << env_width) - 32'd1;
  endfunction

endpackage

// File: rtl/envelope_fsm.sv
// rtl/envelope_fsm.sv - ADSR state and envelope gain register, stepped once per advance strobe
// Option: ENVELOPE_HARD_RETRIG_EN selects hard retrigger (gain forced to 0) from RELEASE.
module envelope_fsm
  import envelope_pkg::*;
#(
  parameter int env_width_p     = 16,
  parameter int attack_step_p   = 16384,
  parameter int decay_step_p    = 8192,
  parameter int sustain_level_p = 32768,
  parameter int release_step_p  = 4096
) (
  input  logic                   clk_i,
  input  logic                   reset_ni,
  input  logic                   advance_i,
  input  logic                   gate_i,
  output logic [env_width_p-1:0] env_o
);

  typedef logic [env_width_p:0] wide_t;

  localparam logic [env_width_p-1:0] max_c     = env_width_p'(env_max(env_width_p));
  localparam logic [env_width_p-1:0] sustain_c = env_width_p'(sustain_level_p);
  localparam logic [env_width_p-1:0] decay_c   = env_width_p'(decay_step_p);
  localparam logic [env_width_p-1:0] release_c = env_width_p'(release_step_p);
  localparam wide_t attack_w      = wide_t'(attack_step_p);
  localparam wide_t release_w     = wide_t'(release_step_p);
  localparam wide_t decay_floor_w = wide_t'(sustain_level_p) + wide_t'(decay_step_p);

  env_state_e             state_q, state_d;
  logic [env_width_p-1:0] env_q, env_d;

  // One extra bit of headroom so the saturation tests see the true sum/difference.
  wide_t                  env_w;
  wide_t                  attack_sum;
  logic                   attack_done;
  logic [env_width_p-1:0] attack_env;

  assign env_w       = {1'b0, env_q};
  assign attack_sum  = env_w + attack_w;
  assign attack_done = attack_sum >= {1'b0, max_c};
  assign attack_env  = attack_done ? max_c : attack_sum[env_width_p-1:0];

  always_ff @(posedge clk_i) begin
    if (!reset_ni) begin
      state_q <= IDLE;
      env_q   <= '0;
    end else begin
      state_q <= state_d;
      env_q   <= env_d;
    end
  end

  always_comb begin
    state_d = state_q;
    env_d   = env_q;
    if (advance_i) begin
      case (state_q)
        IDLE: begin
          env_d = '0;
          if (gate_i) state_d = ATTACK;
        end
        ATTACK: begin
          if (!gate_i) begin
            state_d = RELEASE;
          end else begin
            env_d = attack_env;
            if (attack_done) state_d = DECAY;
          end
        end
        DECAY: begin
          if (!gate_i) begin
            state_d = RELEASE;
          end else if (env_w <= decay_floor_w) begin
            env_d   = sustain_c;
            state_d = SUSTAIN;
          end else begin
            env_d = env_q - decay_c;
          end
        end
        SUSTAIN: begin
          if (!gate_i) state_d = RELEASE;
        end
        RELEASE: begin
          if (gate_i) begin
`ifdef ENVELOPE_HARD_RETRIG_EN
            env_d   = '0;
            state_d = ATTACK;
`else
            env_d   = attack_env;
            state_d = attack_done ? DECAY : ATTACK;
`endif
          end else if (env_w <= release_w) begin
            env_d   = '0;
            state_d = IDLE;
          end else begin
            env_d = env_q - release_c;
          end
        end
        default: begin
          env_d   = '0;
          state_d = IDLE;
        end
      endcase
    end
  end

  assign env_o = env_q;

endmodule

// File: rtl/envelope_adsr.sv
// rtl/envelope_adsr.sv - scales a signed sample stream by an ADSR gain, 1-deep registered output
// Option: ENVELOPE_HARD_RETRIG_EN (in envelope_fsm) selects hard retrigger.
module envelope_adsr
  import envelope_pkg::*;
#(
  parameter int width_p         = 12,
  parameter int env_width_p     = 16,
  parameter int attack_step_p   = 16384,
  parameter int decay_step_p    = 8192,
  parameter int sustain_level_p = 32768,
  parameter int release_step_p  = 4096
) (
  input  logic                      clk_i,
  input  logic                      reset_ni,
  input  logic                      gate_i,
  input  logic                      valid_i,
  input  logic signed [width_p-1:0] data_i,
  output logic                      ready_o,
  output logic                      valid_o,
  output logic signed [width_p-1:0] data_o,
  input  logic                      ready_i
);

  localparam int prod_w = width_p + env_width_p + 1;

  logic                     accept;
  logic [env_width_p-1:0]   env;
  logic signed [prod_w-1:0] data_ext;
  logic signed [prod_w-1:0] env_ext;
  logic signed [prod_w-1:0] prod;
  logic                     prod_unused;

  assign ready_o = ~valid_o | ready_i;
  assign accept  = valid_i & ready_o;

  envelope_fsm #(
    .env_width_p    (env_width_p),
    .attack_step_p  (attack_step_p),
    .decay_step_p   (decay_step_p),
    .sustain_level_p(sustain_level_p),
    .release_step_p (release_step_p)
  ) u_fsm (
    .clk_i    (clk_i),
    .reset_ni (reset_ni),
    .advance_i(accept),
    .gate_i   (gate_i),
    .env_o    (env)
  );

  // Gain is unsigned, so it is zero-extended before the signed multiply.
  assign data_ext = {{(prod_w-width_p){data_i[width_p-1]}}, data_i};
  assign env_ext  = {{(prod_w-env_width_p){1'b0}}, env};
  assign prod     = data_ext * env_ext;

  // Taking the bits above env_width_p is an arithmetic shift, i.e. floor.
  assign prod_unused = ^{prod[prod_w-1], prod[env_width_p-1:0]};

  always_ff @(posedge clk_i) begin
    if (!reset_ni) begin
      valid_o <= 1'b0;
      data_o  <= '0;
    end else if (accept) begin
      valid_o <= 1'b1;
      data_o  <= prod[width_p+env_width_p-1:env_width_p];
    end else if (ready_i) begin
      valid_o <= 1'b0;
    end
  end

endmodule

// File: tb/tb_envelope_adsr.sv
// tb/tb_envelope_adsr.sv - directed and randomized checks of envelope_adsr against a behavioural model
module tb_envelope_adsr;
  import envelope_pkg::*;

  localparam int W   = 12;
  localparam int EW  = 16;
  localparam int A   = 16384;
  localparam int D   = 8192;
  localparam int S   = 32768;
  localparam int R   = 4096;
  localparam int MAX = 65535;

  logic                clk_i    = 1'b0;
  logic                reset_ni = 1'b0;
  logic                gate_i   = 1'b0;
  logic                valid_i  = 1'b0;
  logic                ready_i  = 1'b1;
  logic signed [W-1:0] data_i   = '0;
  logic                ready_o;
  logic                valid_o;
  logic signed [W-1:0] data_o;

  always #5 clk_i = ~clk_i;

  envelope_adsr dut (
    .clk_i   (clk_i),
    .reset_ni(reset_ni),
    .gate_i  (gate_i),
    .valid_i (valid_i),
    .data_i  (data_i),
    .ready_o (ready_o),
    .valid_o (valid_o),
    .data_o  (data_o),
    .ready_i (ready_i)
  );

  int         n_checks = 0;
  int         n_pass   = 0;
  int         m_env    = 0;
  env_state_e m_state  = IDLE;
  bit         m_valid  = 1'b0;
  int         m_data   = 0;

  task automatic check(input string tag, input logic signed [63:0] obs, input logic signed [63:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
  endtask

  function automatic int scale(input int d, input int e);
    longint p;
    p = longint'(d) * longint'(e);
    return int'(p >>> EW);
  endfunction

  task automatic env_rules(input bit g);
    case (m_state)
      IDLE: begin
        m_env = 0;
        if (g) m_state = ATTACK;
      end
      ATTACK: begin
        if (!g) m_state = RELEASE;
        else begin
          m_env = (m_env + A > MAX) ? MAX : m_env + A;
          if (m_env == MAX) m_state = DECAY;
        end
      end
      DECAY: begin
        if (!g) m_state = RELEASE;
        else begin
          m_env = (m_env - D < S) ? S : m_env - D;
          if (m_env == S) m_state = SUSTAIN;
        end
      end
      SUSTAIN: if (!g) m_state = RELEASE;
      RELEASE: begin
        if (g) begin
`ifdef ENVELOPE_HARD_RETRIG_EN
          m_env   = 0;
          m_state = ATTACK;
`else
          m_env   = (m_env + A > MAX) ? MAX : m_env + A;
          m_state = (m_env == MAX) ? DECAY : ATTACK;
`endif
        end else begin
          m_env = (m_env - R < 0) ? 0 : m_env - R;
          if (m_env == 0) m_state = IDLE;
        end
      end
      default: ;
    endcase
  endtask

  task automatic model_edge(input bit rn, input bit v, input bit g, input bit r, input int d);
    bit acc;
    if (!rn) begin
      m_env   = 0;
      m_state = IDLE;
      m_valid = 1'b0;
      m_data  = 0;
    end else begin
      acc = v && (!m_valid || r);
      if (acc) begin
        m_data  = scale(d, m_env);
        m_valid = 1'b1;
        env_rules(g);
      end else if (r && m_valid) begin
        m_valid = 1'b0;
      end
    end
  endtask

  task automatic step(input bit rn, input bit v, input bit g, input bit r, input int d);
    reset_ni = rn;
    valid_i  = v;
    gate_i   = g;
    ready_i  = r;
    data_i   = d[W-1:0];
    @(negedge clk_i);
    check("ready_o", 64'(ready_o), 64'(!m_valid || r));
    @(posedge clk_i);
    model_edge(rn, v, g, r, d);
    #1;
    check("valid_o", 64'(valid_o), 64'(m_valid));
    check("data_o", 64'(data_o), 64'(m_data));
    check("env", 64'(dut.env), 64'(m_env));
    check("state", 64'(dut.u_fsm.state_q), 64'(m_state));
  endtask

  initial begin
    bit g;
    reset_ni = 1'b0;
    @(posedge clk_i);
    #1;
    model_edge(1'b0, 1'b0, 1'b0, 1'b1, 0);

    // Reset held with valid_i asserted, then idle with gate low.
    step(1'b0, 1'b1, 1'b0, 1'b1, 2047);
    step(1'b0, 1'b1, 1'b0, 1'b1, 2047);
    check("reset_valid", 64'(valid_o), 64'(0));
    repeat (3) step(1'b1, 1'b1, 1'b0, 1'b1, 2047);
    check("idle_out", 64'(data_o), 64'(0));

    // Attack to full scale, then a negative full-scale sample at env=max.
    for (int i = 0; i < 10 && m_state != DECAY; i++) step(1'b1, 1'b1, 1'b1, 1'b1, 2047);
    check("attack_max", 64'(dut.env), 64'(MAX));
    step(1'b1, 1'b1, 1'b1, 1'b1, -2048);
    check("attack_floor", 64'(data_o), -64'sd2048);

    // Decay into sustain.
    for (int i = 0; i < 10 && m_state != SUSTAIN; i++) step(1'b1, 1'b1, 1'b1, 1'b1, 2047);
    repeat (3) step(1'b1, 1'b1, 1'b1, 1'b1, 2047);
    check("sustain_out", 64'(data_o), 64'(1023));
    check("sustain_env", 64'(dut.env), 64'(S));

    // Backpressure with output held.
    repeat (5) step(1'b1, 1'b1, 1'b0, 1'b0, 100);
    check("bp_data", 64'(data_o), 64'(1023));
    check("bp_env", 64'(dut.env), 64'(S));
    step(1'b1, 1'b1, 1'b1, 1'b1, 2047);

    // Release to idle, then retrigger from env=16384.
    for (int i = 0; i < 20 && m_state != IDLE; i++) step(1'b1, 1'b1, 1'b0, 1'b1, 2047);
    check("release_idle", 64'(dut.u_fsm.state_q), 64'(IDLE));
    repeat (3) step(1'b1, 1'b1, 1'b1, 1'b1, 2047);
    repeat (5) step(1'b1, 1'b1, 1'b0, 1'b1, 2047);
    check("release_mid", 64'(dut.env), 64'(16384));
    step(1'b1, 1'b1, 1'b1, 1'b1, 2047);
`ifdef ENVELOPE_HARD_RETRIG_EN
    check("retrig_1", 64'(dut.env), 64'(0));
    step(1'b1, 1'b1, 1'b1, 1'b1, 2047);
    check("retrig_2", 64'(dut.env), 64'(16384));
`else
    check("retrig_1", 64'(dut.env), 64'(32768));
    step(1'b1, 1'b1, 1'b1, 1'b1, 2047);
    check("retrig_2", 64'(dut.env), 64'(49152));
`endif

    // Reset in the middle of SUSTAIN with valid_o high.
    for (int i = 0; i < 30 && m_state != SUSTAIN; i++) step(1'b1, 1'b1, 1'b1, 1'b1, 2047);
    check("pre_reset_valid", 64'(valid_o), 64'(1));
    step(1'b0, 1'b1, 1'b1, 1'b1, 2047);
    check("mid_reset_valid", 64'(valid_o), 64'(0));
    check("mid_reset_env", 64'(dut.env), 64'(0));
    check("mid_reset_state", 64'(dut.u_fsm.state_q), 64'(IDLE));

    // Randomized traffic, gate toggles and occasional resets.
    g = 1'b0;
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 9) == 0) g = ~g;
      step(($urandom_range(0, 49) != 0), ($urandom_range(0, 3) != 0), g,
           ($urandom_range(0, 9) < 7), int'($urandom_range(0, 4095)) - 2048);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
